// File: rtl/nine_segment_symbol_sequencer.sv
// Symbol FIFO feeding a 3x3 nine-segment glyph display with a per-glyph dwell timer.
// Optional feature macro: NSEG_BLANK_GAP_EN inserts a blank, busy gap of DWELL
// cycles after every glyph.
module nine_segment_symbol_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_code,
    output logic       in_ready,
    output logic [8:0] segments,
    output logic       busy,
    output logic [4:0] level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 8;
    localparam int unsigned LW = 5;
    localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);

`ifdef NSEG_BLANK_GAP_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1
    } state_t;
`endif

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [8:0]      r_seg;
    logic [8:0]      w_seg_nxt;

    logic [3:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [8:0]      w_head_glyph;

    // Code to 3x3 glyph, bit 3*row+col; codes without a glyph are blank.
    function automatic logic [8:0] glyph(input logic [3:0] code);
        logic [8:0] g;
        case (code)
            4'd0:    g = 9'h1EF;
            4'd1:    g = 9'h092;
            4'd2:    g = 9'h1D7;
            4'd3:    g = 9'h1F7;
            4'd4:    g = 9'h13D;
            4'd5:    g = 9'h1DF;
            4'd6:    g = 9'h1F9;
            4'd7:    g = 9'h127;
            4'd8:    g = 9'h1FF;
            4'd9:    g = 9'h13F;
            default: g = 9'h000;
        endcase
        return g;
    endfunction

    assign w_full       = (r_level == LW'(DEPTH));
    assign w_empty      = (r_level == '0);
    assign in_ready     = rst_n & ~w_full;
    assign w_push       = in_valid & in_ready;
    assign w_head_glyph = glyph(r_mem[r_rd_ptr]);

    // FIFO storage; writes only happen on an accepted transfer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_code;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dwell counter and displayed glyph registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_seg <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    // Next state, pop request and next display contents.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_seg_nxt   = r_seg;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_seg_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_seg_nxt   = w_head_glyph;
                    w_cnt_nxt   = DWELL_M1;
                    w_state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                if (r_cnt == '0) begin
`ifdef NSEG_BLANK_GAP_EN
                    w_seg_nxt   = '0;
                    w_cnt_nxt   = DWELL_M1;
                    w_state_nxt = S_GAP;
`else
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_seg_nxt = w_head_glyph;
                        w_cnt_nxt = DWELL_M1;
                    end else begin
                        w_seg_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
`endif
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
`ifdef NSEG_BLANK_GAP_EN
            S_GAP: begin
                w_seg_nxt = '0;
                if (r_cnt == '0) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_seg_nxt   = w_head_glyph;
                        w_cnt_nxt   = DWELL_M1;
                        w_state_nxt = S_SHOW;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
`endif
            default: begin
                w_seg_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs derived from registered state only.
    always_comb begin
        segments = r_seg;
        busy     = (r_state != S_IDLE);
        level    = r_level;
    end

endmodule

// File: tb/tb_nine_segment_symbol_sequencer.sv
// Bench for nine_segment_symbol_sequencer: a schedule model predicts when each accepted
// code is on display; a monitor compares segments/busy/level/in_ready every cycle.
module tb_nine_segment_symbol_sequencer;

    localparam int DEPTH = 8;
    localparam int DWELL = 4;
`ifdef NSEG_BLANK_GAP_EN
    localparam int BUSY_LEN = 2 * DWELL;
`else
    localparam int BUSY_LEN = DWELL;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_code;
    logic       in_ready;
    logic [8:0] segments;
    logic       busy;
    logic [4:0] level;

    nine_segment_symbol_sequencer #(
        .DEPTH(DEPTH),
        .DWELL(DWELL)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_code (in_code),
        .in_ready(in_ready),
        .segments(segments),
        .busy    (busy),
        .level   (level)
    );

    always #5 clk = ~clk;

    // One scheduled glyph: edge it was accepted on and edge it first appears after.
    typedef struct {
        int         push;
        int         start;
        logic [8:0] glyph;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n    = 0;
    int   next_free = 0;
    int   checks    = 0;
    int   errors    = 0;
    bit   last_acc;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [8:0] ref_glyph(input logic [3:0] c);
        case (c)
            4'd0: return 9'h1EF;
            4'd1: return 9'h092;
            4'd2: return 9'h1D7;
            4'd3: return 9'h1F7;
            4'd4: return 9'h13D;
            4'd5: return 9'h1DF;
            4'd6: return 9'h1F9;
            4'd7: return 9'h127;
            4'd8: return 9'h1FF;
            4'd9: return 9'h13F;
            default: return 9'h000;
        endcase
    endfunction

    // Codes accepted but not yet taken onto the display after edge n.
    function automatic int pending(input int n);
        int cnt = 0;
        foreach (exp_q[i]) if (exp_q[i].start > n) cnt++;
        return cnt;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s edge %0d got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    // Apply one cycle of inputs; schedule the code if the model says it is accepted.
    task automatic drive(input bit v, input logic [3:0] c, input bit rn);
        int t;
        int s;
        bit acc;
        @(negedge clk);
        rst_n    = rn;
        in_valid = v;
        in_code  = c;
        t   = edge_n + 1;
        acc = v && rn && (pending(edge_n) < DEPTH);
        @(posedge clk);
        if (!rn) begin
            exp_q.delete();
            next_free = 0;
        end else if (acc) begin
            s = (next_free > t + 1) ? next_free : t + 1;
            exp_q.push_back('{push: t, start: s, glyph: ref_glyph(c)});
            next_free = s + BUSY_LEN;
        end
        last_acc = acc;
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            drive(1'b0, 4'd0, 1'b1);
            g++;
        end
        drive(1'b0, 4'd0, 1'b1);
        drive(1'b0, 4'd0, 1'b1);
        chk({"drain_", tag}, exp_q.size(), 0);
    endtask

    // Monitor: compare DUT outputs against the schedule after every edge.
    initial begin
        int n;
        int lvl;
        logic [8:0] eseg;
        bit ebusy;
        forever begin
            @(posedge clk);
            #2;
            n = edge_n;
            while (exp_q.size() != 0 && exp_q[0].start + BUSY_LEN <= n) void'(exp_q.pop_front());
            eseg  = 9'h000;
            ebusy = 1'b0;
            foreach (exp_q[i]) begin
                if (exp_q[i].start <= n && n < exp_q[i].start + DWELL) eseg = exp_q[i].glyph;
                if (exp_q[i].start <= n && n < exp_q[i].start + BUSY_LEN) ebusy = 1'b1;
            end
            lvl = pending(n);
            chk("segments", int'(segments), int'(eseg));
            chk("busy", int'(busy), int'(ebusy));
            chk("level", int'(level), lvl);
            chk("in_ready", int'(in_ready), int'(rst_n && (lvl < DEPTH)));
        end
    end

    initial begin
        int idx;
        int guard;
        int dens;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_code  = 4'd0;

        // Reset held with valid asserted: nothing may be queued.
        drive(1'b1, 4'd5, 1'b0);
        drive(1'b1, 4'd5, 1'b0);
        drive(1'b0, 4'd0, 1'b1);
        drive(1'b0, 4'd0, 1'b1);

        // Single symbol.
        drive(1'b1, 4'd1, 1'b1);
        drain("single");

        // Back-to-back symbols.
        drive(1'b1, 4'd2, 1'b1);
        drive(1'b1, 4'd3, 1'b1);
        drain("b2b");

        // Blank codes still occupy a dwell slot.
        drive(1'b1, 4'd10, 1'b1);
        drive(1'b1, 4'd15, 1'b1);
        drain("blank");

        // Hold valid until sixteen codes are taken; FIFO must fill and stall.
        idx   = 0;
        guard = 0;
        while (idx < 16 && guard < 200) begin
            drive(1'b1, 4'(idx), 1'b1);
            if (last_acc) idx++;
            guard++;
        end
        chk("full_fill_count", idx, 16);
        drain("full");

        // Reset while a glyph is showing and codes are queued.
        for (int i = 0; i < 5; i++) drive(1'b1, 4'(i + 4), 1'b1);
        drive(1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 4'd0, 1'b1);

        // Push landing on a glyph expiry edge with an otherwise empty FIFO.
        drive(1'b1, 4'd7, 1'b1);
        for (int i = 0; i < DWELL - 1; i++) drive(1'b0, 4'd0, 1'b1);
        drive(1'b1, 4'd8, 1'b1);
        drain("expiry_push");

        // Randomized traffic with varying density and occasional resets.
        for (int blk = 0; blk < 20; blk++) begin
            dens = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++) begin
                drive(($urandom_range(0, 99) < dens), 4'($urandom_range(0, 15)),
                      ($urandom_range(0, 299) != 0));
            end
        end
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
